// File: rtl/conv_window_buffer_pkg.sv
// Shared constants and helpers for the sliding-window front end.
package conv_window_buffer_pkg;

   localparam int unsigned KERNEL_SIZE_DEFAULT = 4;
   localparam int unsigned PIXEL_WIDTH_DEFAULT = 8;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 0;
      while ((32'd1 << w) < n) begin
         w++;
      end
      if (w == 0) begin
         w = 1;
      end
      return w;
   endfunction

   // Byte slot of window element (row, col) in the flattened window bus.
   function automatic int unsigned win_byte_idx(input int unsigned row,
                                                input int unsigned col,
                                                input int unsigned k);
      return row * k + col;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-row pixel delay: write and read share the column address, so the
// value read at column c is the pixel written at column c one row earlier.
module conv_line_buffer
   import conv_window_buffer_pkg::*;
#(
   parameter int unsigned DEPTH       = 28,
   parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT,
   parameter int unsigned ADDR_WIDTH  = clog2_min1(DEPTH)
) (
   input  logic                   clock,
   input  logic                   write_en,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [PIXEL_WIDTH-1:0] write_data,
   output logic [PIXEL_WIDTH-1:0] read_data
);

   logic [PIXEL_WIDTH-1:0] mem [DEPTH];

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clock) begin
      if (write_en) begin
         mem[addr] <= write_data;
      end
   end

   assign read_data = mem[addr];

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK sliding-window generator feeding mult_adder.
module conv_window_buffer
   import conv_window_buffer_pkg::*;
#(
   parameter int unsigned KERNEL_SIZE  = KERNEL_SIZE_DEFAULT,
   parameter int unsigned IMAGE_WIDTH  = 28,
   parameter int unsigned IMAGE_HEIGHT = 28,
   parameter int unsigned PIXEL_WIDTH  = PIXEL_WIDTH_DEFAULT
) (
   input  logic                                              clock,
   input  logic                                              reset,
   input  logic [PIXEL_WIDTH-1:0]                            pixel_in,
   input  logic                                              pixel_valid,
   output logic [PIXEL_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]    window_out,
   output logic                                              window_valid,
   output logic [clog2_min1(IMAGE_HEIGHT-KERNEL_SIZE+1)-1:0] window_row,
   output logic [clog2_min1(IMAGE_WIDTH-KERNEL_SIZE+1)-1:0]  window_col,
   output logic                                              frame_done
);

   localparam int unsigned K     = KERNEL_SIZE;
   localparam int unsigned ROW_W = clog2_min1(IMAGE_HEIGHT);
   localparam int unsigned COL_W = clog2_min1(IMAGE_WIDTH);
   localparam int unsigned WR_W  = clog2_min1(IMAGE_HEIGHT-KERNEL_SIZE+1);
   localparam int unsigned WC_W  = clog2_min1(IMAGE_WIDTH-KERNEL_SIZE+1);

   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMAGE_HEIGHT-1);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMAGE_WIDTH-1);
   localparam logic [ROW_W-1:0] FULL_ROW  = ROW_W'(K-1);
   localparam logic [COL_W-1:0] FULL_COL  = COL_W'(K-1);
   localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
   localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);

   // Position of the next pixel to arrive.
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;

   logic [PIXEL_WIDTH-1:0] win_q [K][K];
   logic [PIXEL_WIDTH-1:0] lb_wdata [K-1];
   logic [PIXEL_WIDTH-1:0] lb_rdata [K-1];

   logic accept;
   logic completes_window;
   logic last_col;
   logic last_pixel;

   assign accept           = pixel_valid;
   assign last_col         = (col_q == LAST_COL);
   assign last_pixel       = last_col && (row_q == LAST_ROW);
   // Windows that would straddle a row boundary are excluded by the column test.
   assign completes_window = accept && (row_q >= FULL_ROW) && (col_q >= FULL_COL);

   // Line buffer chain: buffer 0 holds the previous row, buffer K-2 the oldest.
   for (genvar j = 0; j < K - 1; j++) begin : g_lb
      if (j == 0) begin : g_head
         assign lb_wdata[j] = pixel_in;
      end else begin : g_tail
         assign lb_wdata[j] = lb_rdata[j-1];
      end

      conv_line_buffer #(
         .DEPTH       (IMAGE_WIDTH),
         .PIXEL_WIDTH (PIXEL_WIDTH),
         .ADDR_WIDTH  (COL_W)
      ) u_line_buffer (
         .clock      (clock),
         .write_en   (accept),
         .addr       (col_q),
         .write_data (lb_wdata[j]),
         .read_data  (lb_rdata[j])
      );
   end

   // Raster position counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
      end else if (accept) begin
         if (last_pixel) begin
            row_q <= '0;
            col_q <= '0;
         end else if (last_col) begin
            row_q <= row_q + ROW_ONE;
            col_q <= '0;
         end else begin
            col_q <= col_q + COL_ONE;
         end
      end
   end

   // Window shift: columns move toward col 0, new column enters at K-1.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
         end
         for (int r = 0; r < K - 1; r++) begin
            win_q[r][K-1] <= lb_rdata[K-2-r];
         end
         win_q[K-1][K-1] <= pixel_in;
      end
   end

   // Valid pulse, coordinates and end-of-frame flag, all one cycle after acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         window_valid <= 1'b0;
         window_row   <= '0;
         window_col   <= '0;
         frame_done   <= 1'b0;
      end else begin
         window_valid <= completes_window;
         frame_done   <= accept && last_pixel;
         if (completes_window) begin
            window_row <= WR_W'(row_q - FULL_ROW);
            window_col <= WC_W'(col_q - FULL_COL);
         end
      end
   end

   // Flatten the window register onto the mult_adder input bus.
   always_comb begin
      window_out = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            window_out[win_byte_idx(r, c, K)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_q[r][c];
         end
      end
   end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer at K=4, 6x6 image.
module tb_conv_window_buffer;

   localparam int K  = 4;
   localparam int W  = 6;
   localparam int H  = 6;
   localparam int NW = 8 * K * K;

   logic          clock;
   logic          reset;
   logic [7:0]    pixel_in;
   logic          pixel_valid;
   logic [NW-1:0] window_out;
   logic          window_valid;
   logic [1:0]    window_row;
   logic [1:0]    window_col;
   logic          frame_done;

   int total = 0;
   int bad   = 0;

   conv_window_buffer #(
      .KERNEL_SIZE  (K),
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .PIXEL_WIDTH  (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .pixel_in     (pixel_in),
      .pixel_valid  (pixel_valid),
      .window_out   (window_out),
      .window_valid (window_valid),
      .window_row   (window_row),
      .window_col   (window_col),
      .frame_done   (frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: record every window pulse.
   logic [NW-1:0] mon_win [$];
   int            mon_row [$];
   int            mon_col [$];
   bit            mon_fd  [$];
   int            fd_count    = 0;
   int            spurious_fd = 0;

   always @(negedge clock) begin
      if (window_valid) begin
         mon_win.push_back(window_out);
         mon_row.push_back(int'(window_row));
         mon_col.push_back(int'(window_col));
         mon_fd.push_back(frame_done);
      end
      if (frame_done) begin
         fd_count++;
         if (!window_valid) spurious_fd++;
      end
   end

   // Driver state: expected valid at next sample and hold tracking.
   bit            prev_qual = 1'b0;
   bit            prev_idle = 1'b0;
   logic [NW-1:0] last_win  = '0;

   task automatic sample_step();
      check("valid_timing", NW'(window_valid), NW'(prev_qual));
      if (prev_idle) check("hold_window", window_out, last_win);
      last_win = window_out;
   endtask

   task automatic run_pixels(input int base, input int n, input bit gap);
      for (int idx = 0; idx < n; idx++) begin
         int r;
         int c;
         r = idx / W;
         c = idx % W;
         @(negedge clock);
         sample_step();
         pixel_in    = 8'(base + r * W + c);
         pixel_valid = 1'b1;
         prev_qual   = (r >= K - 1) && (c >= K - 1);
         prev_idle   = 1'b0;
         if (gap) begin
            @(negedge clock);
            sample_step();
            pixel_valid = 1'b0;
            prev_qual   = 1'b0;
            prev_idle   = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         sample_step();
         pixel_valid = 1'b0;
         prev_qual   = 1'b0;
         prev_idle   = 1'b1;
      end
   endtask

   // Pop and compare the 9 windows of one frame whose pixels are base+r*W+c.
   task automatic check_windows(input int base);
      for (int wr = 0; wr <= H - K; wr++) begin
         for (int wc = 0; wc <= W - K; wc++) begin
            logic [NW-1:0] exp;
            exp = '0;
            for (int rr = 0; rr < K; rr++) begin
               for (int cc = 0; cc < K; cc++) begin
                  exp[8*(rr*K+cc) +: 8] = 8'(base + (wr + rr) * W + wc + cc);
               end
            end
            if (mon_win.size() == 0) begin
               check("window_missing", NW'(0), NW'(1));
            end else begin
               check("window_data", mon_win.pop_front(), exp);
               check("window_row", NW'(mon_row.pop_front()), NW'(wr));
               check("window_col", NW'(mon_col.pop_front()), NW'(wc));
               check("frame_done_align", NW'(mon_fd.pop_front()),
                     NW'((wr == H - K) && (wc == W - K)));
            end
         end
      end
   endtask

   task automatic check_outputs_zero();
      check("rst_window_out", window_out, '0);
      check("rst_window_valid", NW'(window_valid), NW'(0));
      check("rst_window_row", NW'(window_row), NW'(0));
      check("rst_window_col", NW'(window_col), NW'(0));
      check("rst_frame_done", NW'(frame_done), NW'(0));
   endtask

   initial begin
      reset       = 1'b1;
      pixel_in    = '0;
      pixel_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check_outputs_zero();
      last_win = window_out;

      // Continuous single frame.
      run_pixels(0, W * H, 1'b0);
      idle(3);
      check("frame1_count", NW'(mon_win.size()), NW'(9));
      check_windows(0);
      check("frame1_fd", NW'(fd_count), NW'(1));

      // Same frame with a bubble after every pixel.
      run_pixels(0, W * H, 1'b1);
      idle(3);
      check("gap_count", NW'(mon_win.size()), NW'(9));
      check_windows(0);
      check("gap_fd", NW'(fd_count), NW'(2));

      // Two frames with no bubble between them.
      run_pixels(0, W * H, 1'b0);
      run_pixels(100, W * H, 1'b0);
      idle(3);
      check("b2b_count", NW'(mon_win.size()), NW'(18));
      check_windows(0);
      check_windows(100);
      check("b2b_fd", NW'(fd_count), NW'(4));

      // Reset after pixel 25, then a fresh frame.
      run_pixels(0, 26, 1'b0);
      @(negedge clock);
      sample_step();
      pixel_valid = 1'b0;
      reset       = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_outputs_zero();
      prev_qual = 1'b0;
      prev_idle = 1'b0;
      last_win  = window_out;
      check("partial_count", NW'(mon_win.size()), NW'(3));
      mon_win.delete();
      mon_row.delete();
      mon_col.delete();
      mon_fd.delete();
      run_pixels(50, W * H, 1'b0);
      idle(3);
      check("restart_count", NW'(mon_win.size()), NW'(9));
      check_windows(50);
      check("restart_fd", NW'(fd_count), NW'(5));
      check("spurious_fd", NW'(spurious_fd), NW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
